enemy_wave_ctrl: RTL and testbench



---
 rtl/enemy_wave_ctrl_pkg.sv | 21 ++
 rtl/enemy_wave_ctrl_if.sv | 27 ++
 rtl/enemy_wave_ctrl_rr_free_pick.sv | 37 +++
 rtl/enemy_wave_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_enemy_wave_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/enemy_wave_ctrl_pkg.sv
// rtl/enemy_wave_ctrl_pkg.sv - shared types and constants for the enemy wave scheduler
// Purpose: scheduler state encoding, LFSR seed/step, default bottom row.
// Ports: none (package).
package enemy_wave_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } sched_state_t;

  localparam logic [9:0] LFSR_SEED    = 10'h001;
  localparam logic [8:0] BOTTOM_Y_DEF = 9'd440;

  // 10-bit Fibonacci LFSR, taps 10 and 7 (maximal length, never reaches 0
  // from a nonzero seed).
  function automatic logic [9:0] lfsr_next(input logic [9:0] s);
    return {s[8:0], s[9] ^ s[6]};
  endfunction

endpackage

// File: rtl/enemy_wave_ctrl_if.sv
// rtl/enemy_wave_ctrl_if.sv - scheduler <-> enemy bank signal bundle
// Purpose: groups per-slot status inputs and spawn/move controls.
// Ports (master = scheduler side):
//   slot_free/slot_alive/killed [N]  status from the enemy bank
//   enemy_y [9N]                     packed curr_y, slot i at [9i+8:9i]
//   spawn [N], write_x_d [10], move  controls to the enemy bank
interface enemy_wave_ctrl_if #(
  parameter int N = 8
) ();
  logic [N-1:0]   slot_free;
  logic [N-1:0]   slot_alive;
  logic [N-1:0]   killed;
  logic [9*N-1:0] enemy_y;
  logic [N-1:0]   spawn;
  logic [9:0]     write_x_d;
  logic           move;

  modport master (
    input  slot_free, slot_alive, killed, enemy_y,
    output spawn, write_x_d, move
  );

  modport slave (
    output slot_free, slot_alive, killed, enemy_y,
    input  spawn, write_x_d, move
  );
endinterface

// File: rtl/enemy_wave_ctrl_rr_free_pick.sv
// rtl/enemy_wave_ctrl_rr_free_pick.sv - round-robin first-free slot picker
// Purpose: finds the first set bit of free_i at or after ptr_i, wrapping.
// Ports:
//   free_i [N]   candidate slots
//   ptr_i  [IW]  search start
//   grant_o [N]  one-hot chosen slot (0 when none)
//   idx_o  [IW]  index of chosen slot
//   any_o        a free slot exists
module rr_free_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         free_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      // N is a power of two, so the IW-bit add wraps modulo N.
      j = ptr_i + IW'(k);
      if (!any_o && free_i[j]) begin
        grant_o[j] = 1'b1;
        idx_o      = j;
        any_o      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/enemy_wave_ctrl.sv
// rtl/enemy_wave_ctrl.sv - game-level spawn/move/score scheduler for the enemy bank
// Purpose: spawn timing with round-robin slot allocation and random x,
//   shared move pulse, saturating score/level, game-over detection.
// Ports:
//   clk, reset        clock, async active-high reset
//   start             level; starts a game from idle or game over
//   bank (master)     slot status in, spawn/write_x_d/move out
//   score [16]        saturating kill count
//   level [4]         saturating at 15
//   playing           high while playing
//   game_over         high after a live enemy reached the bottom row
module enemy_wave_ctrl
  import enemy_wave_ctrl_pkg::*;
#(
  parameter int         N_ENEMIES       = 8,
  parameter int         SPAWN_TICKS     = 49_999_999,
  parameter int         SPAWN_MIN       = 12_499_999,
  parameter int         SPAWN_STEP      = 4_999_999,
  parameter int         KILLS_PER_LEVEL = 8,
  parameter int         MOVE_TICKS      = 24_999_999,
  parameter int         X_MIN           = 64,
  parameter logic [8:0] BOTTOM_Y        = BOTTOM_Y_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  enemy_wave_ctrl_if.master       bank,
  output logic [15:0]             score,
  output logic [3:0]              level,
  output logic                    playing,
  output logic                    game_over
);
  localparam int IW = $clog2(N_ENEMIES);
  localparam int TW = $clog2(SPAWN_TICKS + 1);
  localparam int MW = $clog2(MOVE_TICKS + 1);
  localparam int KW = $clog2(KILLS_PER_LEVEL + 1);

  sched_state_t         state_q, state_d;
  logic [TW-1:0]        st_q, st_d;
  logic [TW-1:0]        period_q, period_d;
  logic [MW-1:0]        mt_q, mt_d;
  logic                 pend_q, pend_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [9:0]           lfsr_q, lfsr_d;
  logic [N_ENEMIES-1:0] spawn_q, spawn_d;
  logic                 move_q, move_d;
  logic [9:0]           x_q, x_d;
  logic [15:0]          score_q, score_d;
  logic [3:0]           level_q, level_d;
  logic [KW-1:0]        kc_q, kc_d;
  logic [N_ENEMIES-1:0] alive_q;

  logic [N_ENEMIES-1:0] grant;
  logic [IW-1:0]        idx;
  logic                 any_free;
  logic                 bottom_hit;
  logic                 in_play, stay_play, enter_play, tc, issue;
  logic [31:0]          pop, score_sum, kill_total;

  rr_free_pick #(.N(N_ENEMIES)) u_pick (
    .free_i  (bank.slot_free),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (idx),
    .any_o   (any_free)
  );

  always_comb begin
    bottom_hit = 1'b0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (bank.slot_alive[i] && (bank.enemy_y[9*i +: 9] >= BOTTOM_Y)) bottom_hit = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    st_d       = st_q;
    period_d   = period_q;
    mt_d       = '0;
    pend_d     = pend_q;
    rr_d       = rr_q;
    spawn_d    = '0;
    move_d     = 1'b0;
    x_d        = x_q;
    score_d    = score_q;
    level_d    = level_q;
    kc_d       = kc_q;
    lfsr_d     = lfsr_next(lfsr_q);
    tc         = 1'b0;
    issue      = 1'b0;
    pop        = '0;
    score_sum  = '0;
    kill_total = '0;

    case (state_q)
      S_IDLE:  if (start) state_d = S_PLAY;
      S_PLAY:  if (bottom_hit) state_d = S_OVER;
      S_OVER:  if (start) state_d = S_PLAY;
      default: state_d = S_IDLE;
    endcase

    in_play    = (state_q == S_PLAY);
    stay_play  = in_play && (state_d == S_PLAY);
    enter_play = !in_play && (state_d == S_PLAY);

    if (in_play) begin
      // Terminal count uses >= so a period shortened mid-count still wraps.
      tc   = (st_q >= period_q);
      st_d = tc ? '0 : st_q + 1'b1;

      // Spawns are gated on staying in play, so a same-cycle bottom hit wins.
      issue = pend_q && any_free && stay_play;
      if (issue) begin
        spawn_d = grant;
        rr_d    = idx + 1'b1;
        x_d     = 10'(X_MIN) + {1'b0, lfsr_q[8:0]};
      end
      // A terminal count while a request is outstanding collapses into it.
      pend_d = (pend_q && !issue) || tc;

      pop       = 32'($countones(bank.killed & alive_q));
      score_sum = {16'b0, score_q} + pop;
      score_d   = (score_sum > 32'hFFFF) ? 16'hFFFF : score_sum[15:0];

      kill_total = {{(32 - KW){1'b0}}, kc_q} + pop;
      kc_d       = KW'(kill_total % 32'(KILLS_PER_LEVEL));
      // Any number of boundaries crossed in one batch is one level-up.
      if (kill_total >= 32'(KILLS_PER_LEVEL)) begin
        level_d = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
        if ({{(32 - TW){1'b0}}, period_q} >= 32'(SPAWN_MIN + SPAWN_STEP))
          period_d = period_q - TW'(SPAWN_STEP);
        else
          period_d = TW'(SPAWN_MIN);
      end
    end

    if (stay_play) begin
      if (mt_q == MW'(MOVE_TICKS)) move_d = 1'b1;
      else mt_d = mt_q + 1'b1;
    end

    if (enter_play) begin
      score_d  = '0;
      level_d  = '0;
      kc_d     = '0;
      st_d     = '0;
      mt_d     = '0;
      pend_d   = 1'b0;
      period_d = TW'(SPAWN_TICKS);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      st_q     <= '0;
      period_q <= TW'(SPAWN_TICKS);
      mt_q     <= '0;
      pend_q   <= 1'b0;
      rr_q     <= '0;
      lfsr_q   <= LFSR_SEED;
      spawn_q  <= '0;
      move_q   <= 1'b0;
      x_q      <= 10'(X_MIN);
      score_q  <= '0;
      level_q  <= '0;
      kc_q     <= '0;
      alive_q  <= '0;
    end else begin
      state_q  <= state_d;
      st_q     <= st_d;
      period_q <= period_d;
      mt_q     <= mt_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      lfsr_q   <= lfsr_d;
      spawn_q  <= spawn_d;
      move_q   <= move_d;
      x_q      <= x_d;
      score_q  <= score_d;
      level_q  <= level_d;
      kc_q     <= kc_d;
      alive_q  <= bank.slot_alive;
    end
  end

  assign bank.spawn     = spawn_q;
  assign bank.move      = move_q;
  assign bank.write_x_d = x_q;
  assign score          = score_q;
  assign level          = level_q;
  assign playing        = (state_q == S_PLAY);
  assign game_over      = (state_q == S_OVER);

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// tb/tb_enemy_wave_ctrl.sv - self-checking bench for enemy_wave_ctrl
module tb_enemy_wave_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] score;
  logic [3:0]  level;
  logic        playing;
  logic        game_over;

  enemy_wave_ctrl_if #(.N(N)) bank ();

  enemy_wave_ctrl #(
    .N_ENEMIES(N), .SPAWN_TICKS(9), .SPAWN_MIN(3), .SPAWN_STEP(2),
    .KILLS_PER_LEVEL(2), .MOVE_TICKS(4), .X_MIN(64), .BOTTOM_Y(9'd100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bank(bank.master),
    .score(score), .level(level), .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: 0 idle, 1 playing, 2 over.
  int m_state, m_st, m_mt, m_period, m_pend, m_rr, m_lfsr;
  int m_score, m_level, m_kc, m_alive_prev, m_spawn, m_move, m_x;

  int sp_v[$];
  int sp_c[$];
  int mv_c[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_st = 0; m_mt = 0; m_period = 9; m_pend = 0; m_rr = 0;
    m_lfsr = 1; m_score = 0; m_level = 0; m_kc = 0; m_alive_prev = 0;
    m_spawn = 0; m_move = 0; m_x = 64;
  endtask

  task automatic model_step();
    int ns, hit, pop, total, tc, issue, n_spawn, n_move, j, fb;
    if (reset) begin
      model_reset();
      return;
    end
    hit = 0;
    for (int i = 0; i < N; i++)
      if (bank.slot_alive[i] && int'(bank.enemy_y[9*i +: 9]) >= 100) hit = 1;
    ns = m_state;
    if ((m_state == 0 || m_state == 2) && start) ns = 1;
    else if (m_state == 1 && hit) ns = 2;
    n_spawn = 0;
    n_move  = 0;
    if (m_state == 1) begin
      tc    = (m_st >= m_period);
      m_st  = tc ? 0 : m_st + 1;
      issue = 0;
      if (m_pend && bank.slot_free != 0 && ns == 1) begin
        for (int k = 0; k < N && !issue; k++) begin
          j = (m_rr + k) % N;
          if (bank.slot_free[j]) begin
            issue   = 1;
            n_spawn = 1 << j;
            m_rr    = (j + 1) % N;
            m_x     = 64 + (m_lfsr % 512);
          end
        end
      end
      m_pend  = (m_pend && !issue) || tc;
      pop     = $countones(int'(bank.killed) & m_alive_prev);
      m_score = (m_score + pop > 65535) ? 65535 : m_score + pop;
      total   = m_kc + pop;
      m_kc    = total % 2;
      if (total >= 2) begin
        m_level  = (m_level < 15) ? m_level + 1 : 15;
        m_period = (m_period - 2 < 3) ? 3 : m_period - 2;
      end
    end
    if (m_state == 1 && ns == 1) begin
      if (m_mt == 4) begin n_move = 1; m_mt = 0; end
      else m_mt = m_mt + 1;
    end else m_mt = 0;
    if (ns == 1 && m_state != 1) begin
      m_score = 0; m_level = 0; m_kc = 0; m_st = 0; m_mt = 0; m_pend = 0; m_period = 9;
    end
    fb           = ((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1;
    m_lfsr       = ((m_lfsr * 2) % 1024) + fb;
    m_alive_prev = int'(bank.slot_alive);
    m_spawn      = n_spawn;
    m_move       = n_move;
    m_state      = ns;
  endtask

  task automatic compare_all(logic [N-1:0] free_before);
    check("spawn", bank.spawn, m_spawn);
    check("move", bank.move, m_move);
    check("write_x_d", bank.write_x_d, m_x);
    check("score", score, m_score);
    check("level", level, m_level);
    check("playing", playing, m_state == 1);
    check("game_over", game_over, m_state == 2);
    if (bank.spawn != 0) begin
      check("spawn_onehot", $onehot(bank.spawn), 1);
      check("spawn_on_free_slot", bank.spawn & ~free_before, 0);
      check("x_range", (bank.write_x_d >= 64) && (bank.write_x_d <= 575), 1);
    end
  endtask

  task automatic tick();
    logic [N-1:0] fb;
    fb = bank.slot_free;
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    compare_all(fb);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_spawn"}, bank.spawn, 0);
    check({tag, "_move"}, bank.move, 0);
    check({tag, "_x"}, bank.write_x_d, 64);
    check({tag, "_score"}, score, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_playing"}, playing, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  task automatic randomize_bank(int ymax);
    bank.slot_free  = 4'($urandom);
    bank.slot_alive = 4'($urandom);
    bank.killed     = 4'($urandom);
    for (int i = 0; i < N; i++) bank.enemy_y[9*i +: 9] = 9'($urandom_range(0, ymax));
  endtask

  initial begin
    int cnt, held;
    reset = 1'b1;
    start = 1'b0;
    bank.slot_free = '0; bank.slot_alive = '0; bank.killed = '0; bank.enemy_y = '0;
    model_reset();
    #1;
    check_reset_outputs("por");
    tick(); tick();
    reset = 1'b0;

    // Idle: nothing happens without start.
    for (int c = 0; c < 50; c++) begin randomize_bank(511); tick(); end

    // Spawn cadence and round-robin with every slot free.
    bank.slot_free = 4'hF; bank.slot_alive = '0; bank.killed = '0; bank.enemy_y = '0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 62; c++) begin
      tick();
      if (bank.spawn != 0) begin sp_v.push_back(int'(bank.spawn)); sp_c.push_back(cyc); end
      if (bank.move) mv_c.push_back(cyc);
    end
    check("spawn_count", sp_v.size() >= 5, 1);
    for (int i = 0; i < 5 && i < sp_v.size(); i++) check("rr_sequence", sp_v[i], 1 << (i % 4));
    for (int i = 1; i < 5 && i < sp_c.size(); i++) check("spawn_gap", sp_c[i] - sp_c[i-1], 10);
    check("move_count", mv_c.size() >= 4, 1);
    for (int i = 1; i < 4 && i < mv_c.size(); i++) check("move_gap", mv_c[i] - mv_c[i-1], 5);

    // Full bank across two terminal counts, then one slot frees up.
    bank.slot_free = '0;
    cnt = 0;
    for (int c = 0; c < 25; c++) begin tick(); if (bank.spawn != 0) cnt++; end
    check("full_bank_no_spawn", cnt, 0);
    bank.slot_free = 4'b0100;
    tick();
    check("spawn_after_free", bank.spawn, 4'b0100);
    bank.slot_free = '0;
    cnt = 0;
    for (int c = 0; c < 3; c++) begin tick(); if (bank.spawn != 0) cnt++; end
    check("single_spawn_only", cnt, 0);

    // Double kills: each batch is one level-up, period 9->7->5->3->3.
    bank.slot_alive = 4'b0011;
    tick();
    for (int r = 0; r < 4; r++) begin
      bank.killed = 4'b0011; tick(); bank.killed = '0;
      check("level_step", level, r + 1);
      tick(); tick();
    end
    check("score_after_kills", score, 8);
    check("level_after_kills", level, 4);
    bank.slot_alive = '0; bank.slot_free = 4'hF;
    sp_c.delete();
    for (int c = 0; c < 20; c++) begin tick(); if (bank.spawn != 0) sp_c.push_back(cyc); end
    check("fast_spawn_count", sp_c.size() >= 4, 1);
    for (int i = 2; i < 4 && i < sp_c.size(); i++) check("min_period_gap", sp_c[i] - sp_c[i-1], 4);

    // Random play against the model.
    for (int c = 0; c < 150; c++) begin
      randomize_bank(99);
      start = 1'($urandom_range(0, 1));
      tick();
    end
    start = 1'b0;

    // Bottom hit while a spawn is pending and eligible.
    bank.slot_free = '0; bank.slot_alive = '0; bank.killed = '0; bank.enemy_y = '0;
    for (int k = 0; k < 30 && m_pend == 0; k++) tick();
    check("pending_reached", m_pend, 1);
    held = m_score;
    bank.slot_free = 4'hF; bank.slot_alive = 4'b0001; bank.enemy_y[8:0] = 9'd100;
    tick();
    check("hit_game_over", game_over, 1);
    check("hit_no_spawn", bank.spawn, 0);
    check("hit_score_held", score, held);
    for (int c = 0; c < 20; c++) begin randomize_bank(511); tick(); end
    check("over_score_held", score, held);
    check("over_not_playing", playing, 0);
    bank.slot_alive = '0; bank.killed = '0;
    start = 1'b1; tick(); start = 1'b0;
    check("restart_playing", playing, 1);
    check("restart_score", score, 0);
    check("restart_game_over", game_over, 0);

    // Asynchronous reset between edges.
    for (int c = 0; c < 17; c++) begin randomize_bank(99); tick(); end
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    model_reset();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin randomize_bank(511); tick(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
